// File: rtl/cmd_decoder_q_if.sv
// Request/response bus of cmd_decoder_q: one-hot request side in, decoded FIFO head out.
interface cmd_decoder_q_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned ROW_W  = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_read;
    logic              in_write;
    logic              in_activate;
    logic              in_precharge;
    logic              in_refresh;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_cmd;
    logic [BANK_W-1:0] out_bank;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              out_err;

    modport master (
        output in_valid, in_addr, in_read, in_write, in_activate, in_precharge, in_refresh,
        output out_ready,
        input  in_ready,
        input  out_valid, out_cmd, out_bank, out_row, out_col, out_err
    );

    modport slave (
        input  in_valid, in_addr, in_read, in_write, in_activate, in_precharge, in_refresh,
        input  out_ready,
        output in_ready,
        output out_valid, out_cmd, out_bank, out_row, out_col, out_err
    );
endinterface

// File: rtl/cmd_decoder_q.sv
// One-hot memory request decoder feeding a first-word-fall-through FIFO.
// Define CMDDEC_PROTO_CHECK_EN to add per-bank open-row tracking and protocol error flagging.
module cmd_decoder_q #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    cmd_decoder_q_if.slave           bus,
    output logic [15:0]              err_count,
    output logic [(1<<BANK_W)-1:0]   bank_open
);
    localparam int unsigned NB     = 1 << BANK_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned USED_W = COL_W + BANK_W + ROW_W;
    localparam int unsigned ENT_W  = 1 + 4 + BANK_W + ROW_W + COL_W;

    logic [4:0]        strb_c;
    logic [3:0]        cmd_c;
    logic              one_hot_c;
    logic              multi_c;
    logic              proto_err_c;
    logic              err_c;
    logic [COL_W-1:0]  col_c;
    logic [BANK_W-1:0] bank_c;
    logic [ROW_W-1:0]  row_c;
    logic [ENT_W-1:0]  entry_c;
    logic [ENT_W-1:0]  head_c;
    logic              push_c;
    logic              pop_c;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    assign strb_c = {bus.in_refresh, bus.in_precharge, bus.in_activate, bus.in_write, bus.in_read};
    assign col_c  = bus.in_addr[COL_W-1:0];
    assign bank_c = bus.in_addr[COL_W +: BANK_W];
    assign row_c  = bus.in_addr[COL_W+BANK_W +: ROW_W];

    if (ADDR_W > USED_W) begin : g_unused_addr
        logic unused_addr_c;
        assign unused_addr_c = ^bus.in_addr[ADDR_W-1:USED_W];
    end

    // Strobe encoding; anything but exactly one strobe maps to the illegal code
    always_comb begin
        cmd_c = 4'd0;
        case (strb_c)
            5'b00001: cmd_c = 4'd1;
            5'b00010: cmd_c = 4'd2;
            5'b00100: cmd_c = 4'd3;
            5'b01000: cmd_c = 4'd4;
            5'b10000: cmd_c = 4'd5;
            default:  cmd_c = 4'd0;
        endcase
    end

    assign one_hot_c = (cmd_c != 4'd0);
    assign multi_c   = (strb_c != 5'd0) && !one_hot_c;
    assign err_c     = multi_c || (one_hot_c && proto_err_c);

    // in_ready looks only at registered occupancy, so a full FIFO refuses even when popping
    assign bus.in_ready = sys_rst_n && (cnt_q != CNT_W'(DEPTH));
    assign push_c       = bus.in_valid && bus.in_ready && (strb_c != 5'd0);
    assign pop_c        = bus.out_valid && bus.out_ready;

`ifdef CMDDEC_PROTO_CHECK_EN
    logic [NB-1:0]    open_q, open_d;
    logic [ROW_W-1:0] rows_q [NB];

    always_comb begin
        proto_err_c = 1'b0;
        case (cmd_c)
            4'd1, 4'd2: proto_err_c = !open_q[bank_c] || (rows_q[bank_c] != row_c);
            4'd3:       proto_err_c = open_q[bank_c];
            4'd4:       proto_err_c = !open_q[bank_c];
            4'd5:       proto_err_c = |open_q;
            default:    proto_err_c = 1'b0;
        endcase
    end

    always_comb begin
        open_d = open_q;
        if (push_c && cmd_c == 4'd3) open_d[bank_c] = 1'b1;
        if (push_c && cmd_c == 4'd4) open_d[bank_c] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            open_q <= '0;
            for (int i = 0; i < NB; i++) rows_q[i] <= '0;
        end else begin
            open_q <= open_d;
            if (push_c && cmd_c == 4'd3) rows_q[bank_c] <= row_c;
        end
    end

    assign bank_open = open_q;
`else
    assign proto_err_c = 1'b0;
    assign bank_open   = '0;
`endif

    assign entry_c = {err_c, cmd_c, bank_c, row_c, col_c};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_c && !pop_c) cnt_d = cnt_q + CNT_W'(1);
        if (!push_c && pop_c) cnt_d = cnt_q - CNT_W'(1);
        if (push_c && err_c && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero
    always_ff @(posedge sys_clk) begin
        if (push_c) mem_q[wr_ptr_q] <= entry_c;
    end

    assign head_c        = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_err   = head_c[ENT_W-1];
    assign bus.out_cmd   = head_c[ENT_W-2 -: 4];
    assign bus.out_bank  = head_c[COL_W+ROW_W +: BANK_W];
    assign bus.out_row   = head_c[COL_W +: ROW_W];
    assign bus.out_col   = head_c[COL_W-1:0];
    assign err_count     = err_cnt_q;
endmodule

// File: tb/tb_cmd_decoder_q.sv
// Directed self-checking bench for cmd_decoder_q (default parameters, DEPTH=4).
module tb_cmd_decoder_q;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned BANK_W = 3;
    localparam int unsigned ROW_W  = 14;
    localparam int unsigned DEPTH  = 4;
`ifdef CMDDEC_PROTO_CHECK_EN
    localparam bit PROTO = 1'b1;
`else
    localparam bit PROTO = 1'b0;
`endif

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_RD   = 5'b00001;
    localparam logic [4:0] S_WR   = 5'b00010;
    localparam logic [4:0] S_ACT  = 5'b00100;
    localparam logic [4:0] S_PRE  = 5'b01000;
    localparam logic [4:0] S_MULT = 5'b00011;

    logic sys_clk;
    logic sys_rst_n;
    logic [15:0] err_count;
    logic [(1<<BANK_W)-1:0] bank_open;

    int n_assert = 0;
    int n_fail   = 0;
    int ec       = 0;

    cmd_decoder_q_if #(.ADDR_W(ADDR_W), .COL_W(COL_W), .BANK_W(BANK_W), .ROW_W(ROW_W)) bus ();

    cmd_decoder_q #(
        .ADDR_W(ADDR_W), .COL_W(COL_W), .BANK_W(BANK_W), .ROW_W(ROW_W), .DEPTH(DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave),
        .err_count (err_count),
        .bank_open (bank_open)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [31:0] a);
        bus.in_valid     = v;
        bus.in_addr      = a;
        bus.in_read      = s[0];
        bus.in_write     = s[1];
        bus.in_activate  = s[2];
        bus.in_precharge = s[3];
        bus.in_refresh   = s[4];
    endtask

    function automatic logic [31:0] mk_addr(input int bank, input int row, input int col);
        return (32'(row) << 13) | (32'(bank) << 10) | 32'(col);
    endfunction

    initial begin
        sys_rst_n     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, S_NONE, 32'h0);
        #1;
        check("rdy_in_reset", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_cmd", 32'(bus.out_cmd), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_bank_open", 32'(bank_open), 32'd0);

        sys_rst_n = 1'b1;
        tick();
        check("rdy_after_rst", 32'(bus.in_ready), 32'd1);

        // read 0x0001_2345: col 0x345, bank 0, row 9; bank closed when tracking is on
        bus.out_ready = 1'b1;
        drive(1'b1, S_RD, 32'h0001_2345);
        tick();
        drive(1'b0, S_NONE, 32'h0);
        ec = PROTO ? 1 : 0;
        check("rd_valid", 32'(bus.out_valid), 32'd1);
        check("rd_cmd", 32'(bus.out_cmd), 32'd1);
        check("rd_col", 32'(bus.out_col), 32'h345);
        check("rd_bank", 32'(bus.out_bank), 32'd0);
        check("rd_row", 32'(bus.out_row), 32'h9);
        check("rd_err", 32'(bus.out_err), PROTO ? 32'd1 : 32'd0);
        check("rd_errcnt", 32'(err_count), 32'(ec));
        tick();
        check("rd_popped", 32'(bus.out_valid), 32'd0);
        check("empty_cmd_zero", 32'(bus.out_cmd), 32'd0);

        // activate / write / precharge on bank 2 row 5
        drive(1'b1, S_ACT, mk_addr(2, 5, 7));
        tick();
        check("act_cmd", 32'(bus.out_cmd), 32'd3);
        check("act_bank", 32'(bus.out_bank), 32'd2);
        check("act_row", 32'(bus.out_row), 32'd5);
        check("act_err", 32'(bus.out_err), 32'd0);
        check("act_open", 32'(bank_open), PROTO ? 32'h04 : 32'h0);
        drive(1'b1, S_WR, mk_addr(2, 5, 9));
        tick();
        check("wr_cmd", 32'(bus.out_cmd), 32'd2);
        check("wr_col", 32'(bus.out_col), 32'd9);
        check("wr_err", 32'(bus.out_err), 32'd0);
        drive(1'b1, S_PRE, mk_addr(2, 0, 0));
        tick();
        check("pre_cmd", 32'(bus.out_cmd), 32'd4);
        check("pre_err", 32'(bus.out_err), 32'd0);
        check("pre_closed", 32'(bank_open), 32'h0);
        drive(1'b0, S_NONE, 32'h0);
        tick();
        check("seq_drained", 32'(bus.out_valid), 32'd0);
        check("seq_errcnt", 32'(err_count), 32'(ec));

        // fill the FIFO with the consumer stalled
        bus.out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, S_ACT, mk_addr(b, b + 1, 0));
            tick();
        end
        check("full_rdy", 32'(bus.in_ready), 32'd0);
        check("full_valid", 32'(bus.out_valid), 32'd1);
        check("full_head", 32'(bus.out_bank), 32'd0);
        drive(1'b1, S_ACT, mk_addr(4, 9, 0));
        tick();
        check("full_rdy_hold", 32'(bus.in_ready), 32'd0);
        check("stall_bank", 32'(bus.out_bank), 32'd0);
        check("stall_row", 32'(bus.out_row), 32'd1);
        drive(1'b0, S_NONE, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check("drain_rdy", 32'(bus.in_ready), 32'd1);
        check("drain_head1", 32'(bus.out_bank), 32'd1);
        tick();
        check("drain_head2", 32'(bus.out_bank), 32'd2);
        tick();
        check("drain_head3", 32'(bus.out_bank), 32'd3);
        check("drain_row3", 32'(bus.out_row), 32'd4);
        tick();
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("fifth_dropped", 32'(bank_open), PROTO ? 32'h0F : 32'h0);

        // multi-hot then zero-hot
        drive(1'b1, S_MULT, 32'h0);
        tick();
        ec++;
        check("multi_cmd", 32'(bus.out_cmd), 32'd0);
        check("multi_err", 32'(bus.out_err), 32'd1);
        check("multi_errcnt", 32'(err_count), 32'(ec));
        drive(1'b1, S_NONE, mk_addr(5, 1, 1));
        tick();
        check("zero_rdy", 32'(bus.in_ready), 32'd1);
        check("zero_no_entry", 32'(bus.out_valid), 32'd0);
        check("zero_errcnt", 32'(err_count), 32'(ec));
        check("zero_no_state", 32'(bank_open), PROTO ? 32'h0F : 32'h0);

        // reset with three queued entries
        bus.out_ready = 1'b0;
        for (int b = 4; b < 7; b++) begin
            drive(1'b1, S_ACT, mk_addr(b, 2, 0));
            tick();
        end
        drive(1'b0, S_NONE, 32'h0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_open", 32'(bank_open), PROTO ? 32'h7F : 32'h0);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_cmd", 32'(bus.out_cmd), 32'd0);
        check("mid_rst_open", 32'(bank_open), 32'h0);
        check("mid_rst_errcnt", 32'(err_count), 32'd0);
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_rdy", 32'(bus.in_ready), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);

        // saturate the error counter with back-to-back multi-hot requests
        bus.out_ready = 1'b1;
        drive(1'b1, S_MULT, 32'h0);
        for (int i = 0; i < 65534; i++) tick();
        check("sat_near", 32'(err_count), 32'h0000_FFFE);
        for (int i = 0; i < 6; i++) tick();
        check("sat_hold", 32'(err_count), 32'h0000_FFFF);
        check("sat_head_err", 32'(bus.out_err), 32'd1);
        drive(1'b0, S_NONE, 32'h0);
        tick();
        check("sat_final", 32'(err_count), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
